// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline plus memory model.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_flush;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          stall_if;

    logic          d_re;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          stall_mem;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  i_req, i_addr, i_flush, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, stall_if, d_rdata, d_ack, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, i_flush, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, stall_if, d_rdata, d_ack, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one single-ported,
// variable-latency memory, returning one-cycle acks and per-port stalls.
module mem_port_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          drop_q, drop_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;

    logic          i_elig;
    logic          d_elig;
    logic          grant_i;
    logic          grant_d;
    logic          drop_now;

    // A port acked this cycle still shows its finished request, so mask it once.
    always_comb begin
        i_elig   = bus.i_req & ~i_ack_q & ~bus.i_flush;
        d_elig   = (bus.d_re | bus.d_we) & ~d_ack_q;
        grant_i  = i_elig & (~d_elig | (starve_q >= LIMIT_C));
        grant_d  = d_elig & ~grant_i;
        drop_now = drop_q | bus.i_flush;
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (grant_i) begin
                    state_d    = I_ACC;
                    mem_addr_d = bus.i_addr;
                    mem_we_d   = 1'b0;
                    starve_d   = '0;
                end else if (grant_d) begin
                    state_d     = D_ACC;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_we_d    = bus.d_we;
                    if (!bus.i_req) begin
                        starve_d = '0;
                    end else if (starve_q != LIMIT_C) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            I_ACC: begin
                drop_d = drop_now;
                if (bus.mem_ready) begin
                    state_d  = IDLE;
                    drop_d   = 1'b0;
                    mem_we_d = 1'b0;
                    if (!drop_now) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.mem_rdata;
                    end
                end
            end
            D_ACC: begin
                if (bus.mem_ready) begin
                    state_d  = IDLE;
                    d_ack_d  = 1'b1;
                    mem_we_d = 1'b0;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            drop_q      <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.mem_en    = (state_q != IDLE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.stall_if  = bus.i_req & ~i_ack_q;
    assign bus.stall_mem = (bus.d_re | bus.d_we) & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] exp_irdata;
    logic [15:0] exp_drdata;

    // Reference model: the access in flight and the outputs it implies.
    bit          m_busy, m_is_d, m_we, m_drop, m_iack, m_dack;
    logic [15:0] m_addr, m_wdata, m_irdata, m_drdata;
    int          m_starve;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.i_flush   = 1'b0;
        bus.d_re      = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        cyc();
        cyc();
        n_vec++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en got=%0b exp=0", bus.mem_en); end
        n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got=%0b exp=0", bus.mem_we); end
        n_vec++; if (bus.i_ack !== 1'b0) begin n_err++; $display("FAIL rst_i_ack got=%0b exp=0", bus.i_ack); end
        n_vec++; if (bus.d_ack !== 1'b0) begin n_err++; $display("FAIL rst_d_ack got=%0b exp=0", bus.d_ack); end
        n_vec++; if (bus.i_rdata !== 16'h0) begin n_err++; $display("FAIL rst_i_rdata got=%h exp=0000", bus.i_rdata); end
        n_vec++; if (bus.d_rdata !== 16'h0) begin n_err++; $display("FAIL rst_d_rdata got=%h exp=0000", bus.d_rdata); end
        n_vec++; if (bus.mem_addr !== 16'h0) begin n_err++; $display("FAIL rst_mem_addr got=%h exp=0000", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 16'h0) begin n_err++; $display("FAIL rst_mem_wdata got=%h exp=0000", bus.mem_wdata); end
        n_vec++; if (bus.stall_if !== 1'b0) begin n_err++; $display("FAIL rst_stall_if got=%0b exp=0", bus.stall_if); end
        rst_n = 1'b1;
        exp_irdata = 16'h0;
        exp_drdata = 16'h0;
    endtask

    task automatic test_fetch();
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0010;
        cyc();
        n_vec++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL fetch_mem_en got=%0b exp=1", bus.mem_en); end
        n_vec++; if (bus.mem_addr !== 16'h0010) begin n_err++; $display("FAIL fetch_mem_addr got=%h exp=0010", bus.mem_addr); end
        n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_mem_we got=%0b exp=0", bus.mem_we); end
        n_vec++; if (bus.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_wait got=%0b exp=1", bus.stall_if); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hB123;
        cyc();
        n_vec++; if (bus.i_ack !== 1'b1) begin n_err++; $display("FAIL fetch_i_ack got=%0b exp=1", bus.i_ack); end
        n_vec++; if (bus.i_rdata !== 16'hB123) begin n_err++; $display("FAIL fetch_i_rdata got=%h exp=b123", bus.i_rdata); end
        n_vec++; if (bus.stall_if !== 1'b0) begin n_err++; $display("FAIL fetch_stall_ack got=%0b exp=0", bus.stall_if); end
        n_vec++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL fetch_mem_en_ack got=%0b exp=0", bus.mem_en); end
        exp_irdata = 16'hB123;
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b0;
        cyc();
        n_vec++; if (bus.i_ack !== 1'b0) begin n_err++; $display("FAIL fetch_ack_pulse got=%0b exp=0", bus.i_ack); end
    endtask

    task automatic test_both();
        int i_cnt = 0;
        int d_cnt = 0;
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0020;
        bus.d_re   = 1'b1;
        bus.d_addr = 16'h0200;
        cyc();
        i_cnt += int'(bus.i_ack); d_cnt += int'(bus.d_ack);
        n_vec++; if (bus.mem_addr !== 16'h0200) begin n_err++; $display("FAIL both_d_first got=%h exp=0200", bus.mem_addr); end
        n_vec++; if (bus.stall_mem !== 1'b1) begin n_err++; $display("FAIL both_stall_mem got=%0b exp=1", bus.stall_mem); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1111;
        cyc();
        i_cnt += int'(bus.i_ack); d_cnt += int'(bus.d_ack);
        n_vec++; if (bus.d_ack !== 1'b1) begin n_err++; $display("FAIL both_d_ack got=%0b exp=1", bus.d_ack); end
        n_vec++; if (bus.d_rdata !== 16'h1111) begin n_err++; $display("FAIL both_d_rdata got=%h exp=1111", bus.d_rdata); end
        n_vec++; if (bus.stall_mem !== 1'b0) begin n_err++; $display("FAIL both_stall_mem_ack got=%0b exp=0", bus.stall_mem); end
        exp_drdata = 16'h1111;
        bus.d_re      = 1'b0;
        bus.mem_rdata = 16'h2222;
        cyc();
        i_cnt += int'(bus.i_ack); d_cnt += int'(bus.d_ack);
        n_vec++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0020) begin n_err++; $display("FAIL both_i_in_ack_cycle got en=%0b addr=%h exp en=1 addr=0020", bus.mem_en, bus.mem_addr); end
        cyc();
        i_cnt += int'(bus.i_ack); d_cnt += int'(bus.d_ack);
        n_vec++; if (bus.i_rdata !== 16'h2222) begin n_err++; $display("FAIL both_i_rdata got=%h exp=2222", bus.i_rdata); end
        exp_irdata = 16'h2222;
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b0;
        cyc();
        i_cnt += int'(bus.i_ack); d_cnt += int'(bus.d_ack);
        cyc();
        i_cnt += int'(bus.i_ack); d_cnt += int'(bus.d_ack);
        n_vec++; if (i_cnt != 1) begin n_err++; $display("FAIL both_i_ack_count got=%0d exp=1", i_cnt); end
        n_vec++; if (d_cnt != 1) begin n_err++; $display("FAIL both_d_ack_count got=%0d exp=1", d_cnt); end
    endtask

    // The finished port is masked in its ack cycle, which would hand IF the
    // bus after every load; flushing IF in those cycles lets data run ahead.
    task automatic test_starve();
        logic [15:0] seq[$];
        logic [15:0] exp_a;
        bit          prev_en = 1'b0;
        bus.d_re      = 1'b1;
        bus.d_addr    = 16'h0300;
        bus.i_req     = 1'b1;
        bus.i_addr    = 16'h0400;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5150;
        for (int c = 0; c < 80 && seq.size() < 10; c++) begin
            cyc();
            if (bus.mem_en && !prev_en) seq.push_back(bus.mem_addr);
            prev_en     = bus.mem_en;
            bus.i_flush = bus.d_ack;
        end
        n_vec++; if (seq.size() != 10) begin n_err++; $display("FAIL starve_grant_count got=%0d exp=10", seq.size()); end
        for (int k = 0; k < seq.size(); k++) begin
            exp_a = (k == 4 || k == 9) ? 16'h0400 : 16'h0300;
            n_vec++; if (seq[k] !== exp_a) begin n_err++; $display("FAIL starve_grant_%0d got=%h exp=%h", k, seq[k], exp_a); end
        end
        bus.d_re    = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_flush = 1'b0;
        cyc();
        cyc();
        cyc();
        set_idle();
        cyc();
        exp_irdata = 16'h5150;
        exp_drdata = 16'h5150;
    endtask

    task automatic test_flush();
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0050;
        cyc();
        n_vec++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0050) begin n_err++; $display("FAIL flush_grant got en=%0b addr=%h exp en=1 addr=0050", bus.mem_en, bus.mem_addr); end
        bus.i_flush = 1'b1;
        cyc();
        n_vec++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL flush_en_hold2 got=%0b exp=1", bus.mem_en); end
        bus.i_flush = 1'b0;
        cyc();
        n_vec++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL flush_en_hold3 got=%0b exp=1", bus.mem_en); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        cyc();
        n_vec++; if (bus.i_ack !== 1'b0) begin n_err++; $display("FAIL flush_no_ack got=%0b exp=0", bus.i_ack); end
        n_vec++; if (bus.i_rdata !== exp_irdata) begin n_err++; $display("FAIL flush_rdata_kept got=%h exp=%h", bus.i_rdata, exp_irdata); end
        n_vec++; if (bus.stall_if !== 1'b1) begin n_err++; $display("FAIL flush_stall got=%0b exp=1", bus.stall_if); end
        bus.mem_rdata = 16'h7777;
        cyc();
        n_vec++; if (bus.mem_en !== 1'b1 || bus.i_ack !== 1'b0) begin n_err++; $display("FAIL flush_regrant got en=%0b ack=%0b exp en=1 ack=0", bus.mem_en, bus.i_ack); end
        cyc();
        n_vec++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== 16'h7777) begin n_err++; $display("FAIL flush_next_fetch got ack=%0b data=%h exp ack=1 data=7777", bus.i_ack, bus.i_rdata); end
        exp_irdata = 16'h7777;
        set_idle();
        cyc();
    endtask

    task automatic test_store();
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0044;
        bus.d_wdata = 16'h5A5A;
        cyc();
        n_vec++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL store_mem_we got=%0b exp=1", bus.mem_we); end
        n_vec++; if (bus.mem_wdata !== 16'h5A5A) begin n_err++; $display("FAIL store_mem_wdata got=%h exp=5a5a", bus.mem_wdata); end
        n_vec++; if (bus.mem_addr !== 16'h0044) begin n_err++; $display("FAIL store_mem_addr got=%h exp=0044", bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        cyc();
        n_vec++; if (bus.d_ack !== 1'b1) begin n_err++; $display("FAIL store_d_ack got=%0b exp=1", bus.d_ack); end
        n_vec++; if (bus.d_rdata !== exp_drdata) begin n_err++; $display("FAIL store_d_rdata got=%h exp=%h", bus.d_rdata, exp_drdata); end
        set_idle();
        cyc();
        n_vec++; if (bus.d_ack !== 1'b0) begin n_err++; $display("FAIL store_ack_pulse got=%0b exp=0", bus.d_ack); end
    endtask

    task automatic test_reset_mid();
        bus.d_re   = 1'b1;
        bus.d_addr = 16'h0066;
        cyc();
        n_vec++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL rstmid_grant got=%0b exp=1", bus.mem_en); end
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h9999;
        cyc();
        n_vec++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_en got=%0b exp=0", bus.mem_en); end
        n_vec++; if (bus.d_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_d_ack got=%0b exp=0", bus.d_ack); end
        rst_n         = 1'b1;
        bus.mem_ready = 1'b0;
        cyc();
        n_vec++; if (bus.d_ack !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0066) begin n_err++; $display("FAIL rstmid_regrant got ack=%0b en=%0b addr=%h exp ack=0 en=1 addr=0066", bus.d_ack, bus.mem_en, bus.mem_addr); end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h3C3C;
        cyc();
        n_vec++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== 16'h3C3C) begin n_err++; $display("FAIL rstmid_load got ack=%0b data=%h exp ack=1 data=3c3c", bus.d_ack, bus.d_rdata); end
        set_idle();
        cyc();
    endtask

    task automatic model_edge();
        bit ie, de, pick_i, iack_n, dack_n;
        iack_n = 1'b0;
        dack_n = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_drop = 0; m_starve = 0; m_irdata = '0; m_drdata = '0;
        end else if (!m_busy) begin
            ie     = bus.i_req && !m_iack && !bus.i_flush;
            de     = (bus.d_re || bus.d_we) && !m_dack;
            pick_i = ie && (!de || m_starve >= LIMIT);
            if (pick_i) begin
                m_busy = 1; m_is_d = 0; m_addr = bus.i_addr; m_we = 0; m_drop = 0; m_starve = 0;
            end else if (de) begin
                m_busy = 1; m_is_d = 1; m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_we = bus.d_we;
                m_starve = bus.i_req ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            end
        end else begin
            if (!m_is_d && bus.i_flush) m_drop = 1;
            if (bus.mem_ready) begin
                if (!m_is_d && !m_drop) begin iack_n = 1; m_irdata = bus.mem_rdata; end
                if (m_is_d) begin dack_n = 1; if (!m_we) m_drdata = bus.mem_rdata; end
                m_busy = 0;
                m_drop = 0;
            end
        end
        m_iack = iack_n;
        m_dack = dack_n;
    endtask

    task automatic test_random();
        int r;
        rst_n = 1'b0;
        set_idle();
        model_edge();
        cyc();
        for (int c = 0; c < 1500; c++) begin
            n_vec++; if (bus.mem_en !== m_busy) begin n_err++; $display("FAIL rnd_mem_en c=%0d got=%0b exp=%0b", c, bus.mem_en, m_busy); end
            if (m_busy) begin
                n_vec++; if (bus.mem_addr !== m_addr) begin n_err++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, bus.mem_addr, m_addr); end
                n_vec++; if (bus.mem_we !== m_we) begin n_err++; $display("FAIL rnd_mem_we c=%0d got=%0b exp=%0b", c, bus.mem_we, m_we); end
                if (m_we) begin
                    n_vec++; if (bus.mem_wdata !== m_wdata) begin n_err++; $display("FAIL rnd_mem_wdata c=%0d got=%h exp=%h", c, bus.mem_wdata, m_wdata); end
                end
            end
            n_vec++; if (bus.i_ack !== m_iack) begin n_err++; $display("FAIL rnd_i_ack c=%0d got=%0b exp=%0b", c, bus.i_ack, m_iack); end
            n_vec++; if (bus.d_ack !== m_dack) begin n_err++; $display("FAIL rnd_d_ack c=%0d got=%0b exp=%0b", c, bus.d_ack, m_dack); end
            n_vec++; if (bus.i_rdata !== m_irdata) begin n_err++; $display("FAIL rnd_i_rdata c=%0d got=%h exp=%h", c, bus.i_rdata, m_irdata); end
            n_vec++; if (bus.d_rdata !== m_drdata) begin n_err++; $display("FAIL rnd_d_rdata c=%0d got=%h exp=%h", c, bus.d_rdata, m_drdata); end

            rst_n         = ($urandom_range(0, 99) != 0);
            bus.i_req     = ($urandom_range(0, 9) < 7);
            bus.i_addr    = 16'($urandom);
            bus.i_flush   = ($urandom_range(0, 9) == 0);
            r             = $urandom_range(0, 3);
            bus.d_re      = (r == 1 || r == 3);
            bus.d_we      = (r == 2);
            bus.d_addr    = 16'($urandom);
            bus.d_wdata   = 16'($urandom);
            bus.mem_ready = $urandom_range(0, 1) == 1;
            bus.mem_rdata = 16'($urandom);
            #1;
            n_vec++; if (bus.stall_if !== (bus.i_req && !m_iack)) begin n_err++; $display("FAIL rnd_stall_if c=%0d got=%0b exp=%0b", c, bus.stall_if, bus.i_req && !m_iack); end
            n_vec++; if (bus.stall_mem !== ((bus.d_re || bus.d_we) && !m_dack)) begin n_err++; $display("FAIL rnd_stall_mem c=%0d got=%0b exp=%0b", c, bus.stall_mem, (bus.d_re || bus.d_we) && !m_dack); end
            model_edge();
            cyc();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_starve();
        test_flush();
        test_store();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
